// File: rtl/shift_sum_accum_if.sv
// rtl/shift_sum_accum_if.sv - beat input, frame control and result handshake bundle
interface shift_sum_accum_if #(
   parameter int CNT_W = 8,
   parameter int ACC_W = 16
);
   logic             start;
   logic [CNT_W-1:0] frame_len;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       x;
   logic [7:0]       y;
   logic [7:0]       z;
   logic [7:0]       w;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] sum_out;
   logic [7:0]       xor_out;
   logic [CNT_W-1:0] err_cnt;
   logic             err_flag;

   modport master (
      output start, frame_len, in_valid, x, y, z, w, out_ready,
      input  in_ready, busy, out_valid, sum_out, xor_out, err_cnt, err_flag
   );

   modport slave (
      input  start, frame_len, in_valid, x, y, z, w, out_ready,
      output in_ready, busy, out_valid, sum_out, xor_out, err_cnt, err_flag
   );
endinterface

// File: rtl/shift_sum_accum.sv
// rtl/shift_sum_accum.sv - frame accumulator of sum_shift beats with invariant error count
module shift_sum_accum #(
   parameter int CNT_W = 8,
   parameter int ACC_W = 16
) (
   input logic              clk,
   input logic              rst,
   shift_sum_accum_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] beat_cnt;
   logic [ACC_W-1:0] sum_q;
   logic [7:0]       xor_q;
   logic [CNT_W-1:0] err_q;
   logic             err_flag_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             out_valid_q;

   logic [9:0]       chk_sum;
   logic             beat_bad;
   logic             beat_take;
   logic [CNT_W-1:0] beat_next;

   // Invariant check: the 10-bit sum of the three operands, truncated to 8 bits, must equal w.
   always_comb begin
      chk_sum   = {2'b00, bus.x} + {2'b00, bus.y} + {2'b00, bus.z};
      beat_bad  = (bus.w != chk_sum[7:0]);
      beat_take = (state == RUN) && bus.in_valid && in_ready_q;
      beat_next = beat_cnt + CNT_W'(1);
   end

   // Frame FSM with registered handshake outputs and result accumulators.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         len_q       <= '0;
         beat_cnt    <= '0;
         sum_q       <= '0;
         xor_q       <= '0;
         err_q       <= '0;
         err_flag_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sum_q      <= '0;
                  xor_q      <= '0;
                  err_q      <= '0;
                  err_flag_q <= 1'b0;
                  beat_cnt   <= '0;
                  busy_q     <= 1'b1;
                  if (bus.frame_len != '0) begin
                     len_q      <= bus.frame_len;
                     in_ready_q <= 1'b1;
                     state      <= RUN;
                  end else begin
                     // Empty frame: present the all-zero result right away.
                     out_valid_q <= 1'b1;
                     state       <= HOLD;
                  end
               end
            end
            RUN: begin
               if (beat_take) begin
                  sum_q    <= sum_q + ACC_W'(bus.w);
                  xor_q    <= xor_q ^ bus.x ^ bus.y ^ bus.z;
                  beat_cnt <= beat_next;
                  if (beat_bad) begin
                     err_q      <= err_q + CNT_W'(1);
                     err_flag_q <= 1'b1;
                  end
                  if (beat_next == len_q) begin
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     state       <= HOLD;
                  end
               end
            end
            HOLD: begin
               // Results stay in their registers after the handshake until the next start.
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b0;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum_out   = sum_q;
   assign bus.xor_out   = xor_q;
   assign bus.err_cnt   = err_q;
   assign bus.err_flag  = err_flag_q;

endmodule

// File: doc/shift_sum_accum.md
# shift_sum_accum

Frame-level consumer for the 8-bit `sum_shift` datapath stage. It takes the per-cycle `x`, `y`, `z` and `w` results on a valid/ready handshake and accumulates them over a programmed number of beats. For each frame it produces:
- a running sum of `w`,
- an XOR signature of `x^y^z`,
- a count of beats that break the upstream invariant `w == (x+y+z) mod 256`.

Results are held on an output handshake until the downstream checker takes them.

## Interface
Parameters:
- `CNT_W`, default 8: width of the frame length, beat counter and error counter.
- `ACC_W`, default 16: width of the `w` sum accumulator (must be ≥ 8).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  frame start request; sampled only in IDLE.
- `frame_len`  in  CNT_W  number of beats in the frame; sampled with `start`.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `x`, `y`, `z`, `w`  in  8 each  upstream stage results.
- `busy`  out  1  high in RUN and HOLD.
- `out_valid`  out  1  frame results valid.
- `out_ready`  in  1  downstream takes the results.
- `sum_out`  out  ACC_W  sum of `w`, modulo 2^ACC_W.
- `xor_out`  out  8  XOR over all beats of `x^y^z`.
- `err_cnt`  out  CNT_W  number of beats with `w != (x+y+z)[7:0]`.
- `err_flag`  out  1  `err_cnt != 0`.

## Operation
States: IDLE, RUN, HOLD. The state register is encoded explicitly.

IDLE:
- `in_ready=0`, `busy=0`, `out_valid=0`.
- `start=1` with `frame_len>0`: latch `frame_len`, clear the accumulators and the beat counter, go to RUN.
- `start=1` with `frame_len==0`: clear the accumulators, go straight to HOLD. The result is all zero.

RUN:
- `in_ready=1`. A beat is accepted when `in_valid && in_ready`.
- Per accepted beat:
  - `sum += {0, w}`; the add wraps modulo 2^ACC_W.
  - `xor ^= x^y^z`.
  - `err_cnt += 1` if `w != (x+y+z)[7:0]`. The check sum is computed in 10 bits and truncated to 8.
  - Beat counter increments.
- The beat that makes the count equal the latched length is the last beat. Its contribution is included, and the next state is HOLD.
- Cycles with `in_valid=0` change nothing.
- `start` is ignored.

HOLD:
- `out_valid=1`. `sum_out`, `xor_out`, `err_cnt` and `err_flag` are stable and equal the final frame values.
- `in_ready=0`; any upstream beats are not accepted.
- `out_valid && out_ready` → IDLE. The result registers keep their values until the next `start` clears them.
- `start` is ignored.

Other rules:
- `err_cnt` cannot overflow, since its maximum equals the maximum of `frame_len`; no saturation logic.
- Reset, including mid-frame: all state returns to IDLE immediately. All outputs go to 0 (`in_ready`, `busy`, `out_valid`, `sum_out`, `xor_out`, `err_cnt`, `err_flag`). Any partial frame is discarded.

## Timing
- `start` accepted at edge N → RUN and `in_ready=1` from cycle N+1.
- Throughput is 1 beat per cycle with no bubbles while `in_valid` stays high.
- Last beat accepted at edge M → `out_valid=1` in cycle M+1, with final results already registered. Latency is 1 cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Output handshake at edge K → IDLE in K+1. A new `start` is earliest in K+1.
- Minimum frame period is `frame_len` + 2 cycles, plus HOLD wait time.
- A `start` pulse shorter than one cycle or outside IDLE is lost; no queuing.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges → all outputs 0 immediately; state is IDLE after release, with `in_ready=0`.
- **Basic frame:** `frame_len=3`, beats (x,y,z,w) = (1,2,3,0x06), (0x80,0x80,0x01,0x01), (0x10,0x20,0x30,0x61), back-to-back → `out_valid` in the cycle after the 3rd beat with `sum_out=0x0068`, `xor_out=0x01`, `err_cnt=1`, `err_flag=1`. Beat 2 wraps 0x101→0x01 and is not an error.
- **Gaps and backpressure:** same frame with `in_valid` gaps of 0–3 cycles, and `out_ready` held low 5 cycles in HOLD → identical results. Results stay stable while held, and `in_ready=0` throughout HOLD.
- **Zero-length and ignored start:** `frame_len=0` → HOLD the cycle after `start`, all results 0. A `start` pulse during RUN or HOLD has no effect.
- **Accumulator wrap:** with `ACC_W=8` and `frame_len=2`, w = 0xFF, 0xFF (x,y,z chosen consistent) → `sum_out=0xFE`, `err_cnt=0`.
- **Reset mid-frame:** assert `rst` after 2 of 5 beats → IDLE with zero outputs. A following `frame_len=1` frame with (0,0,0,0) → `sum_out=0`, `err_flag=0`; nothing carries over from the aborted frame.
